// File: rtl/vx_commit_arb_pkg.sv
// vx_commit_arb_pkg: commit/writeback beat layouts and field widths shared by the commit arbiter
package vx_commit_arb_pkg;
  localparam int UUID_WIDTH = 44;
  localparam int NW_WIDTH = 2;
  localparam int XLEN = 32;
  localparam int NR_BITS = 5;
  localparam int NUM_THREADS = 4;
  localparam int PERF_CTR_BITS = 44;
  localparam int CDATAW = UUID_WIDTH + NW_WIDTH + XLEN + NUM_THREADS + 1 + NR_BITS + NUM_THREADS * XLEN + 2;
  typedef struct packed {
    logic [UUID_WIDTH-1:0] uuid;
    logic [NW_WIDTH-1:0] wid;
    logic [XLEN-1:0] pc;
    logic [NUM_THREADS-1:0] tmask;
    logic wb;
    logic [NR_BITS-1:0] rd;
    logic [NUM_THREADS*XLEN-1:0] data;
    logic sop;
    logic eop;
  } commit_data_t;
  typedef struct packed {
    logic [UUID_WIDTH-1:0] uuid;
    logic [NW_WIDTH-1:0] wid;
    logic [XLEN-1:0] pc;
    logic [NUM_THREADS-1:0] tmask;
    logic [NR_BITS-1:0] rd;
    logic [NUM_THREADS*XLEN-1:0] data;
    logic eop;
  } wb_data_t;
  function automatic wb_data_t strip(commit_data_t c);
    return '{uuid: c.uuid, wid: c.wid, pc: c.pc, tmask: c.tmask, rd: c.rd, data: c.data, eop: c.eop};
  endfunction
endpackage

// File: rtl/vx_commit_arb_if.sv
// vx_commit_arb_if: commit sources on one side, writeback/done beats on the other
interface vx_commit_arb_if import vx_commit_arb_pkg::*; #(
  parameter int NUM_SRCS = 4
) ();
  logic [NUM_SRCS-1:0] commit_valid;
  logic [NUM_SRCS*CDATAW-1:0] commit_data;
  logic [NUM_SRCS-1:0] commit_ready;
  logic wb_valid;
  wb_data_t wb_data;
  logic done_valid;
  logic [NW_WIDTH-1:0] done_wid;
  modport master (output commit_valid, commit_data, input commit_ready, wb_valid, wb_data, done_valid, done_wid);
  modport slave (input commit_valid, commit_data, output commit_ready, wb_valid, wb_data, done_valid, done_wid);
endinterface

// File: rtl/vx_commit_arb_rr_arbiter.sv
// commit_rr_arbiter: round-robin grant from a rotating pointer, restricted to the owner while a packet is locked
module commit_rr_arbiter #(
  parameter int NUM_SRCS = 4,
  parameter int PW = NUM_SRCS > 1 ? $clog2(NUM_SRCS) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic [NUM_SRCS-1:0] req,
  input  logic lock,
  input  logic [PW-1:0] owner,
  output logic [NUM_SRCS-1:0] grant,
  output logic [PW-1:0] gidx
);
  logic [PW-1:0] ptr_q, ptr_d, idx;
  logic found;
  // first eligible requester at or above ptr; ptr moves past it only on unlocked grants
  always_comb begin
    grant = '0;
    gidx = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_SRCS; k++) begin
      idx = PW'((int'(ptr_q) + k) % NUM_SRCS);
      if (!found && req[idx] && (!lock || idx == owner)) begin
        found = 1'b1;
        gidx = idx;
      end
    end
    if (found) grant[gidx] = 1'b1;
    ptr_d = found && !lock ? PW'((int'(gidx) + 1) % NUM_SRCS) : ptr_q;
  end
  // priority pointer
  always_ff @(posedge clk) ptr_q <= reset ? '0 : ptr_d;
endmodule

// File: rtl/vx_commit_arb.sv
// vx_commit_arb: per-slot commit arbiter driving registered writeback and warp-done beats; COMMIT_ARB_PERF_EN adds perf_commit_stalls
module vx_commit_arb import vx_commit_arb_pkg::*; #(
  parameter int CORE_ID = 0,
  parameter int NUM_SRCS = 4
) (
  input logic clk,
  input logic reset,
  vx_commit_arb_if.slave bus
`ifdef COMMIT_ARB_PERF_EN
  , output logic [PERF_CTR_BITS-1:0] perf_commit_stalls
`endif
);
  localparam int PW = NUM_SRCS > 1 ? $clog2(NUM_SRCS) : 1;
  if (CORE_ID < 0) begin : g_bad_core_id
    $error("CORE_ID must be non-negative");
  end
  logic [NUM_SRCS-1:0] grant;
  logic [PW-1:0] gidx, owner_q, owner_d;
  logic lock_q, lock_d, xfer;
  logic wb_valid_q, wb_valid_d, done_valid_q, done_valid_d;
  wb_data_t wb_data_q, wb_data_d;
  logic [NW_WIDTH-1:0] done_wid_q, done_wid_d;
  commit_data_t beat;
  commit_rr_arbiter #(.NUM_SRCS(NUM_SRCS), .PW(PW)) u_arb (
    .clk(clk),
    .reset(reset),
    .req(bus.commit_valid),
    .lock(lock_q),
    .owner(owner_q),
    .grant(grant),
    .gidx(gidx)
  );
  // accept the granted beat; a multi-beat packet locks the arbiter to its source until eop
  always_comb begin
    bus.commit_ready = reset ? '0 : grant;
    xfer = |bus.commit_ready;
    beat = bus.commit_data[int'(gidx)*CDATAW +: CDATAW];
    lock_d = !xfer ? lock_q : lock_q ? !beat.eop : beat.sop && !beat.eop;
    owner_d = xfer && !lock_q ? gidx : owner_q;
    wb_valid_d = xfer && beat.wb;
    wb_data_d = wb_valid_d ? strip(beat) : wb_data_q;
    done_valid_d = xfer && beat.eop;
    done_wid_d = done_valid_d ? beat.wid : done_wid_q;
  end
  // lock state and registered writeback/done outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q <= 1'b0;
      owner_q <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q <= '0;
      done_valid_q <= 1'b0;
      done_wid_q <= '0;
    end else begin
      lock_q <= lock_d;
      owner_q <= owner_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q <= wb_data_d;
      done_valid_q <= done_valid_d;
      done_wid_q <= done_wid_d;
    end
  end
  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_data = wb_data_q;
  assign bus.done_valid = done_valid_q;
  assign bus.done_wid = done_wid_q;
`ifdef COMMIT_ARB_PERF_EN
  localparam int SW = $clog2(NUM_SRCS + 1);
  logic [SW-1:0] stalls;
  logic [PERF_CTR_BITS-1:0] perf_q, perf_d;
  // add the number of sources held off this cycle; the counter wraps
  always_comb begin
    stalls = '0;
    for (int i = 0; i < NUM_SRCS; i++) stalls = stalls + SW'(bus.commit_valid[i] && !bus.commit_ready[i]);
    perf_d = perf_q + PERF_CTR_BITS'(stalls);
  end
  // stall counter
  always_ff @(posedge clk) perf_q <= reset ? '0 : perf_d;
  assign perf_commit_stalls = perf_q;
`endif
endmodule

// File: tb/tb_vx_commit_arb.sv
// tb_vx_commit_arb: randomized and directed checks of vx_commit_arb against a queue-based reference model
module tb_vx_commit_arb;
  import vx_commit_arb_pkg::*;
  localparam int NS = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  vx_commit_arb_if #(.NUM_SRCS(NS)) bus ();
`ifdef COMMIT_ARB_PERF_EN
  logic [PERF_CTR_BITS-1:0] perf;
`endif
  vx_commit_arb #(.CORE_ID(0), .NUM_SRCS(NS)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef COMMIT_ARB_PERF_EN
    , .perf_commit_stalls(perf)
`endif
  );
  commit_data_t src_q[NS][$];
  logic [NS-1:0] en;
  int m_ptr, m_owner;
  bit m_lock;
  logic exp_wbv, exp_dv;
  wb_data_t exp_wbd;
  logic [NW_WIDTH-1:0] exp_wid;
  logic [PERF_CTR_BITS-1:0] m_perf;
  int checks = 0;
  int errors = 0;
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  function automatic commit_data_t mk(bit sop, bit eop, bit wb, int rd, int wid);
    commit_data_t c;
    c.uuid = UUID_WIDTH'({$urandom(), $urandom()});
    c.wid = NW_WIDTH'(wid);
    c.pc = $urandom();
    c.tmask = $urandom_range(0, 3) == 0 ? '0 : NUM_THREADS'($urandom());
    c.wb = wb;
    c.rd = NR_BITS'(rd);
    c.data = {$urandom(), $urandom(), $urandom(), $urandom()};
    c.sop = sop;
    c.eop = eop;
    return c;
  endfunction
  task automatic push_pkt(input int s, input int len);
    for (int b = 0; b < len; b++)
      src_q[s].push_back(mk(b == 0, b == len - 1, $urandom_range(0, 3) != 0, $urandom_range(0, 31), $urandom_range(0, 3)));
  endtask
  task automatic flush();
    for (int i = 0; i < NS; i++) src_q[i].delete();
  endtask
  // Spec rule: locked -> only the owner; otherwise first valid at/after ptr with wrap.
  function automatic int pick(logic [NS-1:0] v);
    if (m_lock) return v[m_owner] ? m_owner : -1;
    for (int k = 0; k < NS; k++) if (v[(m_ptr + k) % NS]) return (m_ptr + k) % NS;
    return -1;
  endfunction
  task automatic drive(output logic [NS-1:0] v);
    for (int i = 0; i < NS; i++) begin
      v[i] = en[i] && src_q[i].size() > 0;
      bus.commit_data[i*CDATAW +: CDATAW] = src_q[i].size() > 0 ? src_q[i][0] : '0;
    end
    bus.commit_valid = v;
  endtask
  task automatic do_reset();
    logic [NS-1:0] v;
    reset = 1'b1;
    drive(v);
    #1 check("ready_in_reset", bus.commit_ready, '0);
    @(posedge clk);
    @(negedge clk);
    check("rst_wb_valid", bus.wb_valid, 0);
    check("rst_wb_data", bus.wb_data, 0);
    check("rst_done_valid", bus.done_valid, 0);
    check("rst_done_wid", bus.done_wid, 0);
`ifdef COMMIT_ARB_PERF_EN
    check("rst_perf", perf, 0);
`endif
    reset = 1'b0;
    m_ptr = 0;
    m_lock = 0;
    m_owner = 0;
    exp_wbv = 0;
    exp_dv = 0;
    m_perf = '0;
  endtask
  task automatic step(output logic [NS-1:0] g_oh);
    logic [NS-1:0] v;
    commit_data_t b;
    int g;
    check("wb_valid", bus.wb_valid, exp_wbv);
    if (exp_wbv) check("wb_data", bus.wb_data, exp_wbd);
    check("done_valid", bus.done_valid, exp_dv);
    if (exp_dv) check("done_wid", bus.done_wid, exp_wid);
`ifdef COMMIT_ARB_PERF_EN
    check("perf", perf, m_perf);
`endif
    drive(v);
    #1;
    g = pick(v);
    g_oh = g >= 0 ? NS'(1) << g : '0;
    check("commit_ready", bus.commit_ready, g_oh);
    for (int i = 0; i < NS; i++) if (v[i] && !g_oh[i]) m_perf = m_perf + 1'b1;
    exp_wbv = 0;
    exp_dv = 0;
    if (g >= 0) begin
      b = src_q[g].pop_front();
      if (!m_lock) begin
        m_ptr = (g + 1) % NS;
        if (b.sop && !b.eop) begin
          m_lock = 1;
          m_owner = g;
        end
      end else if (b.eop) m_lock = 0;
      exp_wbv = b.wb;
      exp_wbd = '{uuid: b.uuid, wid: b.wid, pc: b.pc, tmask: b.tmask, rd: b.rd, data: b.data, eop: b.eop};
      exp_dv = b.eop;
      exp_wid = b.wid;
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    logic [NS-1:0] g;
    logic [NS-1:0] seq [5] = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
    bit dn [5] = '{1, 0, 0, 1, 1};
    en = '1;
    bus.commit_valid = '0;
    bus.commit_data = '0;
    do_reset();
    src_q[0].push_back(mk(1, 1, 1, 5, 3));
    step(g);
    check("alu_grant", g, 4'b0001);
    check("alu_wb_valid", bus.wb_valid, 1);
    check("alu_rd", bus.wb_data.rd, 5);
    check("alu_done_valid", bus.done_valid, 1);
    check("alu_done_wid", bus.done_wid, 3);
    step(g);
    check("alu_wb_low", bus.wb_valid, 0);
    check("alu_done_low", bus.done_valid, 0);
    do_reset();
    for (int i = 0; i < NS; i++) repeat (4) src_q[i].push_back(mk(1, 1, 1, i, i));
    for (int c = 0; c < 10; c++) begin
      step(g);
      check("rr_grant", g, 1 << (c % 4));
      check("rr_wb_valid", bus.wb_valid, 1);
    end
`ifdef COMMIT_ARB_PERF_EN
    check("perf_30", perf, 30);
`endif
    flush();
    do_reset();
    repeat (4) begin
      src_q[0].push_back(mk(1, 1, 1, 1, 0));
      src_q[2].push_back(mk(1, 1, 1, 2, 2));
    end
    src_q[1].push_back(mk(1, 0, 1, 9, 1));
    src_q[1].push_back(mk(0, 0, 1, 9, 1));
    src_q[1].push_back(mk(0, 1, 1, 9, 1));
    for (int k = 0; k < 5; k++) begin
      step(g);
      check("lsu_grant", g, seq[k]);
      check("lsu_done", bus.done_valid, dn[k]);
    end
    flush();
    src_q[3].push_back(mk(1, 1, 0, 7, 2));
    step(g);
    check("nowb_grant", g, 4'b1000);
    check("nowb_wb_valid", bus.wb_valid, 0);
    check("nowb_done_valid", bus.done_valid, 1);
    check("nowb_done_wid", bus.done_wid, 2);
    flush();
    do_reset();
    src_q[1].push_back(mk(1, 0, 1, 4, 1));
    src_q[1].push_back(mk(0, 0, 1, 4, 1));
    src_q[1].push_back(mk(0, 1, 1, 4, 1));
    step(g);
    check("lock_grant", g, 4'b0010);
    src_q[0].push_back(mk(1, 1, 1, 6, 0));
    do_reset();
    step(g);
    check("post_reset_grant", g, 4'b0001);
    flush();
    do_reset();
    repeat (1500) begin
      for (int i = 0; i < NS; i++)
        if (src_q[i].size() == 0 && $urandom_range(0, 2) != 0) push_pkt(i, $urandom_range(1, 3));
      en = NS'($urandom()) | NS'($urandom());
      step(g);
    end
    en = '0;
    step(g);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
